// File: rtl/multi_dice.sv
// Parametrised multi-die electronic dice: DICE dice of FACES faces advance as an
// odometer while button is held, freeze on release and report a settled total.
module multi_dice #(
  parameter  int FACES  = 6,
  parameter  int DICE   = 2,
  parameter  int SETTLE = 4,
  localparam int W      = $clog2(FACES + 1),
  localparam int SW     = $clog2(DICE * FACES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              button,
  input  logic [DICE-1:0]   hold,
  output logic [DICE*W-1:0] throw,
  output logic [SW-1:0]     sum,
  output logic              stable,
  output logic              roll_done
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [W-1:0]  FACE_MAX   = W'(FACES);
  localparam logic [CW-1:0] SETTLE_MAX = CW'(SETTLE);

  typedef enum logic {
    PH_INIT,
    PH_RUN
  } phase_t;

  phase_t phase_q, phase_d;

  logic [DICE-1:0][W-1:0] die_q, die_d;
  logic [SW-1:0]          sum_q, sum_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   done_q;
  logic                   carry;

  // The first edge after reset is the init step; every later edge is a run step.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_INIT: phase_d = PH_RUN;
      PH_RUN:  phase_d = PH_RUN;
      default: phase_d = PH_INIT;
    endcase
  end

  // Odometer: carry ripples upward, skipping held dice so they neither block
  // nor generate a carry.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    die_d = die_q;
    carry = 1'b1;
    for (int k = 0; k < DICE; k++) begin
      if (!hold[k]) begin
        if (carry) begin
          die_d[k] = (die_q[k] == FACE_MAX) ? W'(1) : die_q[k] + W'(1);
        end
        // NOTE: blocking assignment here so the carry seen by die k+1 is the
        // value just updated for die k within this same evaluation.
        carry = carry & (die_q[k] == FACE_MAX);
      end
    end
  end

  // Total of the values present before the edge; registered, so it lags throw.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < DICE; k++) begin
      sum_d = sum_d + SW'(die_q[k]);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (button) begin
      cnt_d = '0;
    end else if (cnt_q != SETTLE_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    stable_d = (cnt_d == SETTLE_MAX);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every register samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      phase_q  <= PH_INIT;
      die_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sum_q   <= sum_d;
      if (phase_q == PH_INIT) begin
        for (int k = 0; k < DICE; k++) begin
          die_q[k] <= W'(1);
        end
        cnt_q    <= '0;
        stable_q <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        if (button) begin
          die_q <= die_d;
        end
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        done_q   <= stable_d & ~stable_q;
      end
    end
  end

  assign throw     = die_q;
  assign sum       = sum_q;
  assign stable    = stable_q;
  assign roll_done = done_q;

endmodule

// File: tb/tb_multi_dice.sv
// Bench for multi_dice: a default instance (6 faces, 2 dice, settle 4) and a small
// instance (2 faces, 3 dice, settle 1) checked every edge against a mixed-radix model.
module tb_multi_dice;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [1:0] hold_a;
  logic [2:0] hold_b;

  logic [5:0] throw_a;
  logic [3:0] sum_a;
  logic       stable_a, done_a;
  logic [5:0] throw_b;
  logic [2:0] sum_b;
  logic       stable_b, done_b;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  multi_dice #(.FACES(6), .DICE(2), .SETTLE(4)) dut_a (
    .clk(clk), .rst(rst), .button(button), .hold(hold_a),
    .throw(throw_a), .sum(sum_a), .stable(stable_a), .roll_done(done_a)
  );

  multi_dice #(.FACES(2), .DICE(3), .SETTLE(1)) dut_b (
    .clk(clk), .rst(rst), .button(button), .hold(hold_b),
    .throw(throw_b), .sum(sum_b), .stable(stable_b), .roll_done(done_b)
  );

  typedef struct packed {
    logic [7:0][3:0] die;
    logic [7:0]      sum;
    logic [7:0]      cnt;
    logic            stable;
    logic            done;
    logic            init;
  } model_t;

  model_t ma = '0;
  model_t mb = '0;

  // Non-held dice form a mixed-radix number (digit = value-1, lowest index least
  // significant); a roll step adds one to that number modulo FACES^n.
  function automatic model_t model_step(model_t m, int faces, int dice, int settle,
                                        logic r, logic btn, logic [7:0] hold);
    model_t  nx;
    int      total;
    int      idx[$];
    longint  val;
    longint  span;
    nx    = m;
    total = 0;
    val   = 0;
    span  = 1;
    for (int k = 0; k < dice; k++) total += int'(m.die[k]);
    if (r) begin
      nx      = '0;
      nx.init = 1'b1;
      return nx;
    end
    nx.sum = 8'(total);
    if (m.init) begin
      for (int k = 0; k < dice; k++) nx.die[k] = 4'd1;
      nx.cnt    = '0;
      nx.stable = 1'b0;
      nx.done   = 1'b0;
      nx.init   = 1'b0;
      return nx;
    end
    if (btn) begin
      for (int k = 0; k < dice; k++) if (!hold[k]) idx.push_back(k);
      for (int j = idx.size() - 1; j >= 0; j--) begin
        val  = val * faces + longint'(m.die[idx[j]]) - 1;
        span = span * faces;
      end
      val = (val + 1) % span;
      for (int j = 0; j < idx.size(); j++) begin
        nx.die[idx[j]] = 4'((val % faces) + 1);
        val = val / faces;
      end
      nx.cnt = '0;
    end else if (int'(m.cnt) < settle) begin
      nx.cnt = m.cnt + 8'd1;
    end
    nx.stable = (int'(nx.cnt) == settle);
    nx.done   = nx.stable && !m.stable;
    return nx;
  endfunction

  function automatic logic [63:0] pack(model_t m, int w, int dice);
    logic [63:0] v = '0;
    for (int k = 0; k < dice; k++) v |= 64'(m.die[k]) << (k * w);
    return v;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    ma = model_step(ma, 6, 2, 4, rst, button, {6'd0, hold_a});
    mb = model_step(mb, 2, 3, 1, rst, button, {5'd0, hold_b});
    #1;
    check({tag, ".a.throw"},  64'(throw_a),  pack(ma, 3, 2));
    check({tag, ".a.sum"},    64'(sum_a),    64'(ma.sum));
    check({tag, ".a.stable"}, 64'(stable_a), 64'(ma.stable));
    check({tag, ".a.done"},   64'(done_a),   64'(ma.done));
    check({tag, ".b.throw"},  64'(throw_b),  pack(mb, 2, 3));
    check({tag, ".b.sum"},    64'(sum_b),    64'(mb.sum));
    check({tag, ".b.stable"}, 64'(stable_b), 64'(mb.stable));
    check({tag, ".b.done"},   64'(done_b),   64'(mb.done));
  endtask

  initial begin
    rst    = 1'b1;
    button = 1'b0;
    hold_a = '0;
    hold_b = '0;
    repeat (2) tick("reset");
    check("reset.throw_zero", 64'(throw_a), 64'd0);

    rst = 1'b0;
    tick("init");
    check("init.ones", 64'(throw_a), 64'b001_001);
    tick("init_sum");
    check("init.sum2", 64'(sum_a), 64'd2);

    // Full odometer revolution of the 6x6 instance; the 2x2x2 instance
    // completes its 8-state cycle several times alongside.
    button = 1'b1;
    repeat (36) tick("wrap");
    check("wrap.back_to_ones", 64'(throw_a), 64'b001_001);

    repeat (8) tick("to_3_2");
    check("at_3_2", 64'(throw_a), {58'd0, 3'd2, 3'd3});
    hold_a = 2'b01;
    hold_b = 3'b010;
    repeat (10) tick("hold01");
    hold_a = 2'b10;
    hold_b = 3'b101;
    repeat (10) tick("hold10");
    hold_a = 2'b11;
    hold_b = 3'b111;
    repeat (3) tick("hold_all");
    hold_a = '0;
    hold_b = '0;

    repeat (5) tick("settle_roll");
    button = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick("settle_low");
      check("settle.stable_a", 64'(stable_a), 64'(i >= 3));
      check("settle.pulse_a",  64'(done_a),   64'(i == 3));
    end
    button = 1'b1;
    tick("repress");
    check("repress.stable_drop", 64'(stable_a), 64'd0);

    repeat (5) tick("midroll");
    rst = 1'b1;
    tick("midroll_rst");
    check("midroll.zero", 64'(throw_a), 64'd0);
    rst = 1'b0;
    tick("midroll_init");
    check("midroll.ones", 64'(throw_a), 64'b001_001);

    for (int i = 0; i < 400; i++) begin
      button = ($urandom_range(0, 9) < 5);
      if ($urandom_range(0, 3) == 0) begin
        hold_a = 2'($urandom);
        hold_b = 3'($urandom);
      end
      rst = ($urandom_range(0, 63) == 0);
      tick("random");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
